// File: rtl/icache_line_prefetcher.sv
// Next-line I-cache prefetcher with a one-line snooped buffer between the I-cache and the arbiter.
// Define ICACHE_PREFETCH_EN to build the prefetcher; otherwise the block is a pure pass-through.
module icache_line_prefetcher #(
  parameter int unsigned STRIDE = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         icache_read,
  input  logic [31:0]  icache_address,
  output logic [255:0] icache_rdata,
  output logic         icache_resp,
  output logic         arb_read,
  output logic [31:0]  arb_address,
  input  logic [255:0] arb_rdata,
  input  logic         arb_resp,
  input  logic         snoop_write,
  input  logic [31:0]  snoop_address,
  output logic         pf_hit
);

`ifdef ICACHE_PREFETCH_EN
  typedef enum logic [1:0] {IDLE, DEMAND, HIT, PREFETCH} state_t;

  localparam logic [31:0] STRIDE_B = STRIDE[31:0];

  state_t       state, state_nxt;
  logic [255:0] buf_data;
  logic [26:0]  buf_tag;
  logic         buf_valid;
  logic         poison;
  logic [31:0]  pf_addr;
  logic [31:0]  demand_line;
  logic         snoop_buf, snoop_pf, buf_match;
  logic         unused;

  assign demand_line = {icache_address[31:5], 5'b0};
  assign snoop_buf   = snoop_write && (snoop_address[31:5] == buf_tag);
  assign snoop_pf    = snoop_write && (snoop_address[31:5] == pf_addr[31:5]);
  // A write landing on the buffered line in the lookup cycle must not be served stale.
  assign buf_match   = buf_valid && !snoop_buf && (icache_address[31:5] == buf_tag);
  assign unused      = ^{icache_address[4:0], snoop_address[4:0]};

  always_comb begin
    state_nxt    = state;
    arb_read     = 1'b0;
    arb_address  = '0;
    icache_rdata = '0;
    icache_resp  = 1'b0;
    pf_hit       = 1'b0;
    case (state)
      IDLE: begin
        if (icache_read) state_nxt = buf_match ? HIT : DEMAND;
      end
      HIT: begin
        icache_rdata = buf_data;
        icache_resp  = 1'b1;
        pf_hit       = 1'b1;
        state_nxt    = PREFETCH;
      end
      DEMAND: begin
        arb_read     = 1'b1;
        arb_address  = demand_line;
        icache_rdata = arb_rdata;
        icache_resp  = arb_resp;
        if (arb_resp) state_nxt = PREFETCH;
      end
      PREFETCH: begin
        arb_read    = 1'b1;
        arb_address = pf_addr;
        if (arb_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      buf_data  <= '0;
      buf_tag   <= '0;
      buf_valid <= 1'b0;
      poison    <= 1'b0;
      pf_addr   <= '0;
    end else begin
      state <= state_nxt;
      if (snoop_buf) buf_valid <= 1'b0;
      case (state)
        HIT: begin
          buf_valid <= 1'b0;
          pf_addr   <= {buf_tag, 5'b0} + STRIDE_B;
        end
        DEMAND: begin
          if (arb_resp) pf_addr <= demand_line + STRIDE_B;
        end
        PREFETCH: begin
          // Fill overrides the old-tag snoop; a write to the incoming line leaves it invalid.
          if (arb_resp) begin
            buf_data  <= arb_rdata;
            buf_tag   <= pf_addr[31:5];
            buf_valid <= !(poison || snoop_pf);
            poison    <= 1'b0;
          end else if (snoop_pf) begin
            poison <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
`else
  logic unused;

  assign arb_read     = icache_read;
  assign arb_address  = {icache_address[31:5], 5'b0};
  assign icache_rdata = arb_rdata;
  assign icache_resp  = arb_resp;
  assign pf_hit       = 1'b0;
  assign unused       = ^{clk, reset_n, snoop_write, snoop_address, icache_address[4:0]};
`endif

endmodule

// File: tb/tb_icache_line_prefetcher.sv
// Directed bench for icache_line_prefetcher; covers the prefetch build or the pass-through build
// depending on ICACHE_PREFETCH_EN.
module tb_icache_line_prefetcher;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         icache_read;
  logic [31:0]  icache_address;
  logic [255:0] icache_rdata;
  logic         icache_resp;
  logic         arb_read;
  logic [31:0]  arb_address;
  logic [255:0] arb_rdata;
  logic         arb_resp;
  logic         snoop_write;
  logic [31:0]  snoop_address;
  logic         pf_hit;

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 5;
  int cnt     = 0;
  int n;

  icache_line_prefetcher dut (
    .clk(clk), .reset_n(reset_n),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .arb_read(arb_read), .arb_address(arb_address),
    .arb_rdata(arb_rdata), .arb_resp(arb_resp),
    .snoop_write(snoop_write), .snoop_address(snoop_address),
    .pf_hit(pf_hit)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] line(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Checkpoint: 2 time units after the falling edge, when the arbiter model has settled.
  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_resp(input string tag, input int maxc, output int cnt_o);
    cnt_o = 0;
    while (!icache_resp && cnt_o < maxc) begin
      cyc();
      cnt_o++;
    end
    check(tag, icache_resp, 1'b1);
  endtask

  task automatic wait_arb(input string tag, input int maxc);
    int k;
    k = 0;
    while (!arb_resp && k < maxc) begin
      cyc();
      k++;
    end
    check(tag, arb_resp, 1'b1);
  endtask

  // Arbiter model: responds on the lat-th falling edge with arb_read high, for one clock.
  initial begin
    arb_resp  = 1'b0;
    arb_rdata = '0;
    forever begin
      @(negedge clk);
      if (arb_resp) begin
        arb_resp = 1'b0;
        cnt      = 0;
      end else if (arb_read) begin
        cnt++;
        if (cnt >= lat) begin
          arb_resp  = 1'b1;
          arb_rdata = line(arb_address);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
`ifdef ICACHE_PREFETCH_EN
    logic early;
`else
    logic seen;
`endif
    reset_n        = 1'b0;
    icache_read    = 1'b0;
    icache_address = '0;
    snoop_write    = 1'b0;
    snoop_address  = '0;
    cyc();
    cyc();
    check("rst_arb_read", arb_read, 1'b0);
    check("rst_icache_resp", icache_resp, 1'b0);
    check("rst_pf_hit", pf_hit, 1'b0);
    check("rst_arb_address", arb_address, 32'h0);
    check("rst_icache_rdata", icache_rdata, 256'h0);
    reset_n = 1'b1;
    cyc();

`ifdef ICACHE_PREFETCH_EN
    // Cold miss on 0x40, then the 0x60 prefetch.
    icache_read = 1'b1; icache_address = 32'h40;
    cyc();
    check("miss_arb_read", arb_read, 1'b1);
    check("miss_arb_addr", arb_address, 32'h40);
    wait_resp("miss_resp", 20, n);
    check("miss_latency", n, 4);
    check("miss_resp_with_arb", arb_resp, 1'b1);
    check("miss_data", icache_rdata, line(32'h40));
    check("miss_pf_hit", pf_hit, 1'b0);
    cyc(); icache_read = 1'b0;
    check("pf_issue", arb_read, 1'b1);
    check("pf_addr_60", arb_address, 32'h60);
    check("pf_no_resp", icache_resp, 1'b0);
    wait_arb("pf60_fill", 20);
    cyc();
    check("idle_after_fill", arb_read, 1'b0);

    // Hit on 0x64 from the buffered 0x60 line, then the 0x80 prefetch.
    icache_read = 1'b1; icache_address = 32'h64;
    cyc();
    check("hit_resp", icache_resp, 1'b1);
    check("hit_pf_hit", pf_hit, 1'b1);
    check("hit_data", icache_rdata, line(32'h60));
    cyc(); icache_read = 1'b0;
    check("hit_pf_read", arb_read, 1'b1);
    check("hit_pf_addr", arb_address, 32'h80);

    // Demand 0x100 while the 0x80 prefetch is outstanding.
    icache_read = 1'b1; icache_address = 32'h100;
    early = 1'b0; n = 0;
    while (!arb_resp && n < 20) begin
      if (icache_resp) early = 1'b1;
      cyc();
      n++;
    end
    check("pend_pf_done", arb_resp, 1'b1);
    check("pend_pf_addr", arb_address, 32'h80);
    check("pend_no_early_resp", early, 1'b0);
    cyc();
    check("pend_idle", arb_read, 1'b0);
    cyc();
    check("pend_demand_addr", arb_address, 32'h100);
    wait_resp("pend_resp", 20, n);
    check("pend_data", icache_rdata, line(32'h100));
    check("pend_pf_hit", pf_hit, 1'b0);
    cyc(); icache_read = 1'b0;
    check("pf_addr_120", arb_address, 32'h120);
    wait_arb("pf120_fill", 20);
    cyc();

    // Snoop write into the buffered 0x120 line forces a miss.
    snoop_write = 1'b1; snoop_address = 32'h128;
    cyc();
    snoop_write = 1'b0;
    icache_read = 1'b1; icache_address = 32'h120;
    cyc();
    check("snoop_miss_read", arb_read, 1'b1);
    check("snoop_miss_addr", arb_address, 32'h120);
    check("snoop_miss_pf_hit", pf_hit, 1'b0);
    wait_resp("snoop_resp", 20, n);
    cyc(); icache_read = 1'b0;

    // Snoop hitting the in-flight 0x140 prefetch poisons it.
    check("pf_addr_140", arb_address, 32'h140);
    snoop_write = 1'b1; snoop_address = 32'h144;
    cyc();
    snoop_write = 1'b0;
    wait_arb("pf140_fill", 20);
    cyc();
    icache_read = 1'b1; icache_address = 32'h140;
    cyc();
    check("poison_miss_read", arb_read, 1'b1);
    check("poison_miss_pf_hit", pf_hit, 1'b0);
    wait_resp("poison_resp", 20, n);
    cyc(); icache_read = 1'b0;
    wait_arb("pf160_fill", 20);
    cyc();

    // Top-of-memory wrap, then reset in the middle of the prefetch.
    icache_read = 1'b1; icache_address = 32'hFFFF_FFE4;
    cyc();
    check("wrap_demand_addr", arb_address, 32'hFFFF_FFE0);
    wait_resp("wrap_resp", 20, n);
    cyc(); icache_read = 1'b0;
    check("wrap_pf_read", arb_read, 1'b1);
    check("wrap_pf_addr", arb_address, 32'h0);
    cyc();
    reset_n = 1'b0;
    #1;
    check("rst_drops_arb_read", arb_read, 1'b0);
    check("rst_drops_arb_addr", arb_address, 32'h0);
    cyc();
    reset_n = 1'b1;
    cyc();
    icache_read = 1'b1; icache_address = 32'h0;
    cyc();
    check("post_rst_miss", arb_read, 1'b1);
    check("post_rst_pf_hit", pf_hit, 1'b0);
    wait_resp("post_rst_resp", 20, n);
    check("post_rst_data", icache_rdata, line(32'h0));
    cyc(); icache_read = 1'b0;
    wait_arb("pf20_fill", 20);
    cyc();
`else
    // Pass-through: demand straight to the arbiter, no follow-up prefetch.
    icache_read = 1'b1; icache_address = 32'h44;
    #1;
    check("pt_arb_read", arb_read, 1'b1);
    check("pt_arb_addr", arb_address, 32'h40);
    wait_resp("pt_resp", 20, n);
    check("pt_latency", n, 5);
    check("pt_data", icache_rdata, line(32'h40));
    check("pt_pf_hit", pf_hit, 1'b0);
    snoop_write = 1'b1; snoop_address = 32'h40;
    cyc();
    icache_read = 1'b0; snoop_write = 1'b0;
    #1;
    check("pt_no_pf", arb_read, 1'b0);
    seen = 1'b0;
    repeat (4) begin
      cyc();
      if (arb_read) seen = 1'b1;
    end
    check("pt_quiet", seen, 1'b0);
    icache_read = 1'b1; icache_address = 32'hFFFF_FFFF;
    #1;
    check("pt_arb_addr_hi", arb_address, 32'hFFFF_FFE0);
    wait_resp("pt_resp_hi", 20, n);
    check("pt_data_hi", icache_rdata, line(32'hFFFF_FFE0));
    cyc(); icache_read = 1'b0;
    cyc();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
